// File: rtl/dbus_sram_responder.sv
// Core dbus responder driving one asynchronous 32-bit SRAM; stalls the core for the whole access.
// States: IDLE wait req | RD_WAIT oe asserted | WR_SETUP/WR_PULSE/WR_HOLD write strobe phases | DONE stall low.
module dbus_sram_responder #(
  parameter int ADDR_W      = 20,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dbus_address,
  input  logic [3:0]        dbus_byteenable,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [31:0]       dbus_wrdata,
  output logic [31:0]       dbus_rddata,
  output logic              dbus_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_MAX = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rddata;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [31:0]        r_sram_data_o;
  logic               r_sram_data_oe;
  logic               r_sram_ce_n;
  logic               r_sram_oe_n;
  logic               r_sram_we_n;
  logic [3:0]         r_sram_be_n;

  logic w_req;
  logic w_busy;
  logic w_unused_addr;

  // Upper address bits are dropped on purpose so the SRAM space aliases.
  assign w_unused_addr = ^{dbus_address[31:ADDR_W+2], dbus_address[1:0]};

  assign w_req  = dbus_read | dbus_write;
  assign w_busy = (r_state == S_RD_WAIT) || (r_state == S_WR_SETUP) ||
                  (r_state == S_WR_PULSE) || (r_state == S_WR_HOLD);
  assign dbus_stall = (w_req && (r_state != S_DONE)) || w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rddata       <= '0;
      r_sram_addr    <= '0;
      r_sram_data_o  <= '0;
      r_sram_data_oe <= 1'b0;
      r_sram_ce_n    <= 1'b1;
      r_sram_oe_n    <= 1'b1;
      r_sram_we_n    <= 1'b1;
      r_sram_be_n    <= 4'hF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_sram_addr <= dbus_address[ADDR_W+1:2];
            r_sram_be_n <= ~dbus_byteenable;
            r_sram_ce_n <= 1'b0;
            if (dbus_write) begin
              r_sram_data_o  <= dbus_wrdata;
              r_sram_data_oe <= 1'b1;
              r_sram_we_n    <= 1'b1;
              r_state        <= S_WR_SETUP;
            end else begin
              r_sram_oe_n <= 1'b0;
              r_cnt       <= CNT_W'(READ_WAIT - 1);
              r_state     <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_rddata    <= sram_data_i;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_sram_be_n <= 4'hF;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_SETUP: begin
          r_sram_we_n <= 1'b0;
          r_cnt       <= CNT_W'(WRITE_PULSE - 1);
          r_state     <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (r_cnt == '0) begin
            r_sram_we_n <= 1'b1;
            r_state     <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_HOLD: begin
          r_sram_ce_n    <= 1'b1;
          r_sram_data_oe <= 1'b0;
          r_sram_be_n    <= 4'hF;
          r_state        <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbus_rddata  = r_rddata;
  assign sram_addr    = r_sram_addr;
  assign sram_data_o  = r_sram_data_o;
  assign sram_data_oe = r_sram_data_oe;
  assign sram_ce_n    = r_sram_ce_n;
  assign sram_oe_n    = r_sram_oe_n;
  assign sram_we_n    = r_sram_we_n;
  assign sram_be_n    = r_sram_be_n;

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
Responder end of the CPU data bus. It accepts single read and write requests from the core's dbus, and drives one external asynchronous 32-bit SRAM with separate data-in and data-out plus a tri-state enable. It holds the core with dbus_stall for the full access time and returns read data in the cycle stall drops. It sits between naive_mips and the board SRAM pins, replacing the zero-wait behavioural memory.

Parameters:
ADDR_W, 20, SRAM word-address width; maps dbus_address[ADDR_W+1:2].
READ_WAIT, 2, cycles the SRAM outputs are enabled before read data is captured; minimum 1.
WRITE_PULSE, 2, cycles sram_we_n is held low; minimum 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
dbus_address  in  32  byte address; bits [1:0] ignored
dbus_byteenable  in  4  byte lanes; bit0 = data[7:0]
dbus_read  in  1  read request, held while stalled
dbus_write  in  1  write request, held while stalled
dbus_wrdata  in  32  write data
dbus_rddata  out  32  read data, valid in the DONE cycle
dbus_stall  out  1  core must hold request
sram_addr  out  ADDR_W  word address
sram_data_o  out  32  data to SRAM
sram_data_i  in  32  data from SRAM
sram_data_oe  out  1  pad driver enable for sram_data_o
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte lane enables, active low

Behaviour:
- Reset: rst is sampled on the clk edge. On reset: state IDLE, counter 0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_data_o=0, dbus_rddata=0.
- Reset mid-access aborts the access. All SRAM strobes are inactive from the next edge. No DONE cycle is produced.
- A request is present when dbus_read or dbus_write is high. If both are high, the access is a write. This is a protocol violation, and the bench flags it with an assertion.
- dbus_stall is combinational and equals request AND (state != DONE). It is also held high in any busy state regardless of request. The stall therefore rises in the same cycle a request first appears in IDLE.
- All SRAM outputs and dbus_rddata are registered.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE with a read: latch the word address into sram_addr. Set sram_be_n = ~byteenable, ce_n=0, oe_n=0, counter=READ_WAIT-1. Go to RD_WAIT.
- RD_WAIT: if counter==0, capture sram_data_i into dbus_rddata, set ce_n=1, oe_n=1, be_n=F, and go to DONE. Otherwise decrement the counter.
- Read latency: a request first seen in cycle T gives stall high in T..T+READ_WAIT and low in T+READ_WAIT+1 (DONE), with data valid in that DONE cycle.
- All 32 read bits are captured. Byte and halfword extraction is done by the core.
- IDLE with a write: latch the address, set sram_data_o=wrdata, sram_be_n=~byteenable, data_oe=1, ce_n=0, we_n=1. Go to WR_SETUP.
- WR_SETUP (1 cycle): set we_n=0, counter=WRITE_PULSE-1, go to WR_PULSE.
- WR_PULSE: while counter!=0, decrement. When counter==0, set we_n=1 and go to WR_HOLD.
- WR_HOLD (1 cycle): address and data still driven. Then set ce_n=1, data_oe=0, be_n=F and go to DONE.
- Write latency: 3+WRITE_PULSE cycles of stall, then the DONE cycle.
- A write with byteenable=0 runs the full sequence with be_n=F and modifies no byte.
- Address, data and byte enables never change while we_n=0. data_oe is never high while oe_n=0.
- DONE: lasts exactly 1 cycle with stall low, then returns to IDLE unconditionally.
- Back-to-back requests: a request held in the cycle after DONE starts a fresh access from IDLE. Each access has minimum spacing of latency+1 cycles.
- dbus_rddata holds its value until the next read capture. Writes do not change it.
- Address bits above ADDR_W+1 are ignored, so the SRAM space aliases (wraps).

Test Plan:
1. Reset with READ_WAIT=2, then SRAM model word 0x10 = 0xDEADBEEF. Issue read at byte address 0x40, be=F. Required: stall high for 3 cycles, low on the 4th, and dbus_rddata=0xDEADBEEF in that cycle. Also sram_oe_n low for exactly 2 cycles.
2. Write 0x11223344 to address 0x80 with be=4'b0101, WRITE_PULSE=2, over a prior word 0xAAAAAAAA. Required: we_n low for exactly 2 cycles, stall high for 5 cycles. A following read returns 0xAA22AA44.
3. Back-to-back: write 0xCAFEF00D to 0x100, then immediately hold a read of 0x100. Required: the read starts the cycle after DONE and returns 0xCAFEF00D. There is no lost or duplicated access, checked by SRAM access count = 2.
4. Assert rst during WR_PULSE. Required: at the next edge we_n=1, ce_n=1, data_oe=0, state IDLE, stall=0 with no request present.
5. Address wrap with ADDR_W=4: write 0x5 to byte address 0x40, read byte address 0x0. Required: data 0x5.
6. Check signal constraints on every cycle of a 200-op random read/write mix. While we_n=0, addr, data and be are stable. data_oe and ~oe_n are never high together. Stall is never low in a busy state.
